ram_fifo_ctrl: RTL and testbench

Wraps the single-port 64x4 RAM_memory as a 64-entry FIFO and drives its Enable/ReadWrite/Address/DataIn inputs directly. It consumes the RAM's DataOut into a one-entry output register.
- Upstream producers use a valid/ready push interface.
- Downstream consumers use a valid/ready pop interface.
- Arbitration gives the RAM port each cycle to at most one access: a prefetch read or a write.

---
 rtl/ram_fifo_pkg.sv | 18 +
 rtl/ram_fifo_ctrl_if.sv | 27 ++
 rtl/ram_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_ram_fifo_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// ram_fifo_pkg
// Shared sizing constants for the RAM-backed FIFO controller.
//   DATA_W      : data width, equal to the RAM DataIn/DataOut width
//   ADDR_W      : RAM address width
//   DEPTH       : RAM entries (2**ADDR_W)
//   RCNT_W      : width of the RAM occupancy counter (0..DEPTH)
//   CNT_W       : width of the total occupancy count (0..DEPTH+2)
package ram_fifo_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int RCNT_W = ADDR_W + 1;
  localparam int CNT_W  = ADDR_W + 2;

  localparam logic [RCNT_W-1:0] RAM_CNT_FULL = RCNT_W'(DEPTH);

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// ram_fifo_ctrl_if
// Push (producer) and pop (consumer) valid/ready handshakes of the FIFO.
//   push_valid/push_ready/push_data : producer side
//   pop_valid/pop_ready/pop_data    : consumer side
// Modports:
//   slave  : the FIFO controller
//   master : the environment driving pushes and taking pops
interface ram_fifo_ctrl_if import ram_fifo_pkg::*; ();

  logic              push_valid;
  logic              push_ready;
  logic [DATA_W-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DATA_W-1:0] pop_data;

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

endinterface

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl
// Runs a single-port 64x4 RAM as a 64-entry FIFO with a one-entry output
// register holding the head. Each cycle the RAM port carries at most one
// access: a prefetch read into the output register, or a write of pushed data.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : synchronous clear of all contents
//   fifo            : push/pop handshakes (slave modport)
//   Enable          : RAM access strobe
//   ReadWrite       : 1 = write, 0 = read
//   Address, DataIn : RAM address and write data
//   DataOut         : RAM read data, valid the cycle after the read is issued
//   count           : entries held in RAM + in flight + output register
//   full, empty     : RAM full / nothing held anywhere
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  ram_fifo_ctrl_if.slave      fifo,
  output logic                Enable,
  output logic                ReadWrite,
  output logic [ADDR_W-1:0]   Address,
  output logic [DATA_W-1:0]   DataIn,
  input  logic [DATA_W-1:0]   DataOut,
  output logic [CNT_W-1:0]    count,
  output logic                full,
  output logic                empty
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [RCNT_W-1:0] ram_cnt_q, ram_cnt_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic pop_fire;
  logic rd_go;
  logic wr_go;

  always_comb begin
    full  = (ram_cnt_q == RAM_CNT_FULL);
    count = CNT_W'(ram_cnt_q) + CNT_W'(rd_inflight_q) + CNT_W'(out_valid_q);
    empty = (count == '0);

    fifo.pop_valid = out_valid_q & ~flush;
    fifo.pop_data  = out_data_q;
    pop_fire       = fifo.pop_valid & fifo.pop_ready;

    // Prefetch whenever the output register is free or being emptied this
    // cycle; reads win the port, so push_ready sees pop_ready combinationally.
    rd_go = rst_n & ~flush & ~rd_inflight_q & (ram_cnt_q != '0) &
            (~out_valid_q | pop_fire);
    fifo.push_ready = rst_n & ~flush & ~full & ~rd_go;
    wr_go = fifo.push_valid & fifo.push_ready;

    Enable    = rd_go | wr_go;
    ReadWrite = wr_go;
    Address   = wr_go ? wr_ptr_q : rd_ptr_q;
    DataIn    = wr_go ? fifo.push_data : '0;
  end

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    ram_cnt_d     = ram_cnt_q;
    rd_inflight_d = rd_go;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;

    if (wr_go) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q + 1'b1;
    end
    if (rd_go) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      ram_cnt_d = ram_cnt_q - 1'b1;
    end

    if (rd_inflight_q) begin
      out_data_d  = DataOut;
      out_valid_d = 1'b1;
    end else if (pop_fire) begin
      out_valid_d = 1'b0;
    end

    // An in-flight read result is dropped along with everything else.
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      ram_cnt_d     = '0;
      rd_inflight_d = 1'b0;
      out_valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      ram_cnt_q     <= '0;
      rd_inflight_q <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      ram_cnt_q     <= ram_cnt_d;
      rd_inflight_q <= rd_inflight_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl
// Self-checking bench for ram_fifo_ctrl with a behavioural single-port RAM.
module tb_ram_fifo_ctrl;
  import ram_fifo_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              Enable;
  logic              ReadWrite;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] DataIn;
  logic [DATA_W-1:0] DataOut;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;

  ram_fifo_ctrl_if fifo ();

  ram_fifo_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fifo      (fifo),
    .Enable    (Enable),
    .ReadWrite (ReadWrite),
    .Address   (Address),
    .DataIn    (DataIn),
    .DataOut   (DataOut),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write at the enabling edge, read data registered at the
  // enabling edge so it is captured by the controller one edge later.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (Enable) begin
      if (ReadWrite) mem[Address] <= DataIn;
      else           DataOut <= mem[Address];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard: data queued on accepted push, compared on accepted pop.
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] sb_exp;
  int                pops_seen = 0;
  logic              saw_wrap = 1'b0;
  logic              have_prev = 1'b0;
  logic [ADDR_W-1:0] prev_rd_addr = '0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (fifo.pop_valid && fifo.pop_ready) begin
          pops_seen++;
          if (sb.size() == 0) begin
            chk("pop_unexpected", 1, 0);
          end else begin
            sb_exp = sb.pop_front();
            chk("pop_data_sb", int'(fifo.pop_data), int'(sb_exp));
          end
        end
        if (fifo.push_valid && fifo.push_ready) sb.push_back(fifo.push_data);
      end
      if (Enable && !ReadWrite) begin
        if (have_prev && prev_rd_addr == 6'd63 && Address == 6'd0) saw_wrap = 1'b1;
        prev_rd_addr = Address;
        have_prev    = 1'b1;
      end
    end
  end

  typedef struct {
    logic              pv;
    logic [DATA_W-1:0] pd;
    logic              pr;
    logic              fl;
    logic              e_en;
    logic              e_rw;
    logic [ADDR_W-1:0] e_addr;
    logic              e_prdy;
    logic              e_popv;
    logic [DATA_W-1:0] e_popd;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic pv, input logic [DATA_W-1:0] pd,
                       input logic pr, input logic fl);
    @(negedge clk);
    fifo.push_valid = pv;
    fifo.push_data  = pd;
    fifo.pop_ready  = pr;
    flush           = fl;
    #1;
  endtask

  initial begin
    int n;
    int cyc;

    // pv pd pr fl | en rw addr prdy popv popd cnt
    vecs.push_back('{1'b1, 4'hA, 1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0, 4'h0, 8'd0});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0, 4'h0, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 4'h0, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b1, 4'hA, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd1, 1'b1, 1'b0, 4'h0, 8'd0});
    vecs.push_back('{1'b1, 4'hB, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 1'b1, 1'b0, 4'h0, 8'd0});
    vecs.push_back('{1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0, 1'b0, 4'h0, 8'd1});
    vecs.push_back('{1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 1'b1, 6'd2, 1'b1, 1'b0, 4'h0, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2, 1'b1, 1'b1, 4'hB, 8'd2});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0, 1'b1, 4'hB, 8'd2});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b0, 4'h0, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b1, 4'hC, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3, 1'b1, 1'b0, 4'h0, 8'd0});

    // Reset held with a pending push
    rst_n           = 1'b0;
    flush           = 1'b0;
    fifo.push_valid = 1'b1;
    fifo.push_data  = 4'h7;
    fifo.pop_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enable", int'(Enable), 0);
    chk("rst_push_ready", int'(fifo.push_ready), 0);
    chk("rst_pop_valid", int'(fifo.pop_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_address", int'(Address), 0);
    @(negedge clk);
    fifo.push_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rel_push_ready", int'(fifo.push_ready), 1);

    // Single-entry latency and read-priority sequences
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pv, vecs[i].pd, vecs[i].pr, vecs[i].fl);
      chk($sformatf("v%0d_enable", i), int'(Enable), int'(vecs[i].e_en));
      chk($sformatf("v%0d_readwrite", i), int'(ReadWrite), int'(vecs[i].e_rw));
      chk($sformatf("v%0d_address", i), int'(Address), int'(vecs[i].e_addr));
      chk($sformatf("v%0d_push_ready", i), int'(fifo.push_ready), int'(vecs[i].e_prdy));
      chk($sformatf("v%0d_pop_valid", i), int'(fifo.pop_valid), int'(vecs[i].e_popv));
      if (vecs[i].e_popv)
        chk($sformatf("v%0d_pop_data", i), int'(fifo.pop_data), int'(vecs[i].e_popd));
      chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_cnt));
      chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].e_cnt == 0));
    end

    // Fill with no pops: 64 in RAM plus one in the output register
    n = 0;
    cyc = 0;
    while (n < 65 && cyc < 400) begin
      drive(1'b1, n[3:0], 1'b0, 1'b0);
      if (fifo.push_ready) n++;
      cyc++;
    end
    chk("fill_accepted", n, 65);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 4'h0, 1'b0, 1'b0);
      chk("full_push_ready", int'(fifo.push_ready), 0);
      chk("full_enable", int'(Enable), 0);
      chk("full_flag", int'(full), 1);
      chk("full_count", int'(count), 65);
    end

    // Drain everything across the address wrap
    pops_seen = 0;
    saw_wrap  = 1'b0;
    cyc = 0;
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    while (count != 0 && cyc < 400) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      cyc++;
    end
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("drain_pops", pops_seen, 65);
    chk("drain_addr_wrap", int'(saw_wrap), 1);
    chk("drain_count", int'(count), 0);
    chk("drain_empty", int'(empty), 1);

    // Flush during a read issue cycle
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 100) begin
      drive(1'b1, 4'((n + 3) % 16), 1'b0, 1'b0);
      if (fifo.push_ready) n++;
      cyc++;
    end
    chk("flush_fill", n, 10);
    cyc = 0;
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    while (!(Enable && !ReadWrite) && cyc < 20) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      cyc++;
    end
    chk("flush_read_issue_seen", int'(Enable && !ReadWrite), 1);
    flush = 1'b1;
    #1;
    chk("flush_enable", int'(Enable), 0);
    chk("flush_pop_valid", int'(fifo.pop_valid), 0);
    chk("flush_push_ready", int'(fifo.push_ready), 0);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_flush_count", int'(count), 0);
    chk("post_flush_pop_valid", int'(fifo.pop_valid), 0);
    chk("post_flush_empty", int'(empty), 1);
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    chk("post_flush_idle_pop", int'(fifo.pop_valid), 0);
    drive(1'b1, 4'h5, 1'b1, 1'b0);
    chk("post_flush_wr_en", int'(Enable), 1);
    chk("post_flush_wr_rw", int'(ReadWrite), 1);
    chk("post_flush_wr_addr", int'(Address), 0);
    cyc = 0;
    drive(1'b0, 4'h0, 1'b1, 1'b0);
    while (!fifo.pop_valid && cyc < 10) begin
      drive(1'b0, 4'h0, 1'b1, 1'b0);
      cyc++;
    end
    chk("post_flush_pop_valid_seen", int'(fifo.pop_valid), 1);
    chk("post_flush_pop_data", int'(fifo.pop_data), 5);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    chk("post_flush_final_empty", int'(empty), 1);

    // Reset in the middle of traffic
    drive(1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b1, 4'h2, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_count", int'(count), 0);
    chk("midrst_push_ready", int'(fifo.push_ready), 0);
    chk("midrst_enable", int'(Enable), 0);
    chk("midrst_pop_valid", int'(fifo.pop_valid), 0);
    drive(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("midrst_rel_push_ready", int'(fifo.push_ready), 1);
    chk("midrst_rel_empty", int'(empty), 1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
